// File: rtl/matrix_stream_serializer.sv
// matrix_stream_serializer: double-buffered matrix gather; one bank loads randomly addressed
// elements while the other streams row-major as MSB-first OUT_WIDTH-bit chunks.
module matrix_stream_serializer #(
    parameter int ELEMENT_WIDTH = 8,
    parameter int OUT_WIDTH = 2,
    parameter int MAX_ROWS = 32,
    parameter int MAX_COLS = 32
) (
    input  logic                         eth_refclk,
    input  logic                         rst,
    input  logic [$clog2(MAX_ROWS):0]    cfg_rows,
    input  logic [$clog2(MAX_COLS):0]    cfg_cols,
    input  logic                         valid_data_in,
    input  logic [$clog2(MAX_ROWS)-1:0]  row_addr,
    input  logic [$clog2(MAX_COLS)-1:0]  col_addr,
    input  logic [ELEMENT_WIDTH-1:0]     matrix_element,
    input  logic                         data_request,
    output logic                         load_ready,
    output logic                         matrix_pending,
    output logic [OUT_WIDTH-1:0]         dout,
    output logic                         valid_data_out,
    output logic                         last_out,
    output logic                         write_err
);
    localparam int RW = $clog2(MAX_ROWS);
    localparam int CW = $clog2(MAX_COLS);
    localparam int AW = RW + CW;
    localparam int DEPTH = MAX_ROWS * MAX_COLS;
    localparam int NW = AW + 1;
    localparam int CPE = ELEMENT_WIDTH / OUT_WIDTH;
    localparam int KW = CPE > 1 ? $clog2(CPE) : 1;

    typedef enum logic [1:0] {EMPTY, LOADING, FULL, SENDING} bank_t;
    typedef enum logic [1:0] {IDLE, PREFETCH, STREAM} send_t;

    bank_t bank_st [2];
    bank_t bank_nx [2];
    send_t st, st_nx;
    logic wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
    logic [RW:0] rows_q [2];
    logic [CW:0] cols_q [2];
    logic [DEPTH-1:0] bitmap [2];
    logic [NW-1:0] cnt [2];
    logic [ELEMENT_WIDTH-1:0] mem [2*DEPTH];
    logic [ELEMENT_WIDTH-1:0] rd_data, shifted;

    logic wr_empty, wr_open, in_range, accept, is_new, bank_done;
    logic [RW:0] eff_rows;
    logic [CW:0] eff_cols;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [NW-1:0] cnt_nx, total;

    logic [KW-1:0] k;
    logic [RW-1:0] cur_r, nxt_r;
    logic [CW-1:0] cur_c, nxt_c;
    logic [RW:0] row_lim;
    logic [CW:0] col_lim;
    logic start, last_chunk, last_col, last_elem, rd_en;

    // Range checks use the latched size once loading has begun; an EMPTY bank uses live cfg.
    always_comb begin
        wr_empty = bank_st[wr_ptr] == EMPTY;
        wr_open = wr_empty || bank_st[wr_ptr] == LOADING;
        eff_rows = wr_empty ? cfg_rows : rows_q[wr_ptr];
        eff_cols = wr_empty ? cfg_cols : cols_q[wr_ptr];
        in_range = {1'b0, row_addr} < eff_rows && {1'b0, col_addr} < eff_cols;
        accept = valid_data_in && wr_open && in_range;
        wr_addr = {row_addr, col_addr};
        is_new = !bitmap[wr_ptr][wr_addr];
        cnt_nx = cnt[wr_ptr] + NW'(is_new);
        total = NW'(eff_rows) * NW'(eff_cols);
        bank_done = accept && cnt_nx == total;
    end

    always_comb begin
        start = st == IDLE && data_request && bank_st[rd_ptr] == FULL;
        last_chunk = k == KW'(CPE - 1);
        row_lim = rows_q[rd_ptr] - (RW+1)'(1);
        col_lim = cols_q[rd_ptr] - (CW+1)'(1);
        last_col = {1'b0, cur_c} == col_lim;
        last_elem = last_col && {1'b0, cur_r} == row_lim;
        nxt_c = last_col ? '0 : cur_c + CW'(1);
        nxt_r = last_col ? cur_r + RW'(1) : cur_r;
        rd_en = st == PREFETCH || (st == STREAM && last_chunk && !last_elem);
        rd_addr = st == PREFETCH ? '0 : {nxt_r, nxt_c};
        shifted = rd_data << (OUT_WIDTH * k);
        st_nx = st;
        if (start) st_nx = PREFETCH;
        else if (st == PREFETCH) st_nx = STREAM;
        else if (st == STREAM && last_chunk && last_elem) st_nx = IDLE;
    end

    // A bank is released the cycle its last chunk is on dout, so last_out doubles as the release strobe.
    always_comb begin
        bank_nx = bank_st;
        wr_ptr_nx = bank_done ? !wr_ptr : wr_ptr;
        rd_ptr_nx = last_out ? !rd_ptr : rd_ptr;
        if (accept) bank_nx[wr_ptr] = bank_done ? FULL : LOADING;
        if (start) bank_nx[rd_ptr] = SENDING;
        if (last_out) bank_nx[rd_ptr] = EMPTY;
    end

    always_ff @(posedge eth_refclk) begin
        if (accept && !rst) mem[{wr_ptr, wr_addr}] <= matrix_element;
        if (rd_en) rd_data <= mem[{rd_ptr, rd_addr}];
    end

    always_ff @(posedge eth_refclk) begin
        if (rst) begin
            bank_st <= '{EMPTY, EMPTY};
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            bitmap <= '{default: '0};
            cnt <= '{default: '0};
            load_ready <= 1'b0;
            matrix_pending <= 1'b0;
            write_err <= 1'b0;
        end else begin
            bank_st <= bank_nx;
            wr_ptr <= wr_ptr_nx;
            rd_ptr <= rd_ptr_nx;
            load_ready <= bank_nx[wr_ptr_nx] == EMPTY || bank_nx[wr_ptr_nx] == LOADING;
            matrix_pending <= bank_nx[0] == FULL || bank_nx[1] == FULL;
            write_err <= valid_data_in && !accept;
            if (accept) begin
                bitmap[wr_ptr][wr_addr] <= 1'b1;
                cnt[wr_ptr] <= cnt_nx;
            end
            if (accept && wr_empty) begin
                rows_q[wr_ptr] <= cfg_rows;
                cols_q[wr_ptr] <= cfg_cols;
            end
            if (last_out) begin
                bitmap[rd_ptr] <= '0;
                cnt[rd_ptr] <= '0;
            end
        end
    end

    always_ff @(posedge eth_refclk) begin
        if (rst) begin
            st <= IDLE;
            dout <= '0;
            valid_data_out <= 1'b0;
            last_out <= 1'b0;
        end else begin
            st <= st_nx;
            dout <= st == STREAM ? shifted[ELEMENT_WIDTH-1 -: OUT_WIDTH] : '0;
            valid_data_out <= st == STREAM;
            last_out <= st == STREAM && last_chunk && last_elem;
            if (st == PREFETCH) begin
                k <= '0;
                cur_r <= '0;
                cur_c <= '0;
            end else if (st == STREAM) begin
                k <= last_chunk ? '0 : k + KW'(1);
                if (last_chunk) begin
                    cur_r <= nxt_r;
                    cur_c <= nxt_c;
                end
            end
        end
    end
endmodule
